// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, byte width,
// default inter-message gap and a one-hot to index helper.
package uart_arb_pkg;

  localparam int BYTE_W             = 8;
  localparam int GAP_CYCLES_DEFAULT = 15000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    BUSY = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational requester picker producing a one-hot grant.
// Default build: round-robin, searching upward from ptr with wrap.
// With UART_ARB_FIXED_PRIORITY_EN defined: lowest-index requester wins and
// ptr is ignored.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

`ifdef UART_ARB_FIXED_PRIORITY_EN
  logic ptr_unused;
  assign ptr_unused = ^ptr;

  // Isolate the lowest set bit: plain priority encoder.
  always_comb begin
    gnt = req & (~req + N_REQ'(1));
  end
`else
  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] gnt_dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_gnt;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    rot     = req_dbl[N_REQ-1:0];
    rot_gnt = rot & (~rot + N_REQ'(1));
    gnt_dbl = {rot_gnt, rot_gnt} << ptr;
    gnt     = gnt_dbl[2*N_REQ-1:N_REQ];
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular arbiter sharing one UART byte transmitter between N_REQ
// byte-stream requesters. A grant is held until the requester's last byte has
// left the transmitter, then an idle gap of GAP_CYCLES clocks is inserted.
// Build option UART_ARB_FIXED_PRIORITY_EN selects fixed lowest-index priority
// instead of round-robin.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT,
  parameter int GAP_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]       tx_word,
  output logic                    tx_start,
  input  logic                    tx_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_t         state_reg;
  logic [N_REQ-1:0]   grant_reg;
  logic [N_REQ-1:0]   req_ready_reg;
  logic [BYTE_W-1:0]  tx_word_reg;
  logic               tx_start_reg;
  logic               last_reg;
  logic               first_reg;
  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;

  logic [BYTE_W-1:0]  req_bytes [N_REQ];
  logic [N_REQ-1:0]   pick_gnt;
  logic [BYTE_W-1:0]  sel_byte;
  logic               sel_valid;
  logic               sel_last;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data[BYTE_W*gi +: BYTE_W];
    end
  endgenerate

  rr_pick #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_pick (
    .req(req_valid),
    .ptr(rr_ptr_reg),
    .gnt(pick_gnt)
  );

  // Steer the granted requester's byte, valid and last flag (grant is one-hot).
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_reg[i]) sel_byte = sel_byte | req_bytes[i];
    end
    sel_valid = |(req_valid & grant_reg);
    sel_last  = |(req_last & grant_reg);
  end

`ifndef UART_ARB_FIXED_PRIORITY_EN
  logic [2:0]       grant_idx;
  logic [PTR_W-1:0] next_ptr;

  // Round-robin pointer moves to the requester after the current owner.
  always_comb begin
    grant_idx = onehot_to_idx(8'(grant_reg));
    next_ptr  = '0;
    if (grant_idx != 3'(N_REQ - 1)) next_ptr = PTR_W'(grant_idx + 3'd1);
  end
`endif

  // Arbiter FSM: pick owner, hand bytes to the transmitter, then idle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      req_ready_reg <= '0;
      tx_word_reg   <= '0;
      tx_start_reg  <= 1'b0;
      last_reg      <= 1'b0;
      first_reg     <= 1'b0;
      rr_ptr_reg    <= '0;
      gap_cnt_reg   <= '0;
    end else begin
      tx_start_reg  <= 1'b0;
      req_ready_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (|req_valid) begin
            grant_reg <= pick_gnt;
            state_reg <= SEND;
          end
        end
        SEND: begin
          // A stalled owner keeps the grant; there is no timeout.
          if (tx_ready && sel_valid) begin
            tx_word_reg   <= sel_byte;
            last_reg      <= sel_last;
            tx_start_reg  <= 1'b1;
            req_ready_reg <= grant_reg;
            first_reg     <= 1'b1;
            state_reg     <= BUSY;
          end
        end
        BUSY: begin
          // tx_ready only drops after the transmitter has seen tx_start.
          if (first_reg) begin
            first_reg <= 1'b0;
          end else if (tx_ready) begin
            if (last_reg) begin
`ifdef UART_ARB_FIXED_PRIORITY_EN
              rr_ptr_reg <= '0;
`else
              rr_ptr_reg <= next_ptr;
`endif
              grant_reg   <= '0;
              gap_cnt_reg <= '0;
              state_reg   <= (GAP_CYCLES > 0) ? GAP : IDLE;
            end else begin
              state_reg <= SEND;
            end
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_reg <= '0;
            state_reg   <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign tx_word   = tx_word_reg;
  assign tx_start  = tx_start_reg;
  assign grant     = grant_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Two instances (gap 20 and gap 0)
// share requester and transmitter models; the unused one is held in reset.
module tb_uart_tx_arbiter;

  localparam int N       = 2;
  localparam int G_A     = 20;
  localparam int TX_BUSY = 10;

  typedef struct { logic [7:0] data; logic last; int delay; } item_t;
  typedef struct { int req; logic [7:0] data; logic last; } exp_t;
  typedef struct { int req; int len; logic [23:0] bytes; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic sel = 1'b0;
  logic rst_a, rst_b;
  assign rst_a = rst | sel;
  assign rst_b = rst | ~sel;

  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [8*N-1:0] req_data  = '0;
  logic           tx_ready  = 1'b1;

  logic [N-1:0] a_req_ready, b_req_ready, a_grant, b_grant;
  logic [7:0]   a_tx_word, b_tx_word;
  logic         a_tx_start, b_tx_start, a_busy, b_busy;

  logic [N-1:0] req_ready, grant;
  logic [7:0]   tx_word;
  logic         tx_start, busy;
  assign req_ready = sel ? b_req_ready : a_req_ready;
  assign grant     = sel ? b_grant     : a_grant;
  assign tx_word   = sel ? b_tx_word   : a_tx_word;
  assign tx_start  = sel ? b_tx_start  : a_tx_start;
  assign busy      = sel ? b_busy      : a_busy;

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(G_A), .GAP_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(a_req_ready), .tx_word(a_tx_word),
    .tx_start(a_tx_start), .tx_ready(tx_ready), .grant(a_grant), .busy(a_busy));

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(0), .GAP_W(16)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(b_req_ready), .tx_word(b_tx_word),
    .tx_start(b_tx_start), .tx_ready(tx_ready), .grant(b_grant), .busy(b_busy));

  item_t rq[N][$];
  int    hold[N];
  exp_t  sb[$];
  int    deltas[$];
  int    tests = 0, failed = 0;
  int    starts_seen = 0, cyc = 0, rise_cyc = 0, tcnt = 0;
  logic  armed = 1'b0, pending_last = 1'b0, ready_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Requester models: present queue front, pop on req_ready, optional stall.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      automatic int h = hold[i];
      if (req_ready[i] && rq[i].size() > 0) begin
        void'(rq[i].pop_front());
        h = (rq[i].size() > 0) ? rq[i][0].delay : 0;
      end else if (h > 0) begin
        h--;
      end
      hold[i] <= h;
      if (rq[i].size() > 0 && h == 0) begin
        req_valid[i]     <= 1'b1;
        req_data[8*i +: 8] <= rq[i][0].data;
        req_last[i]      <= rq[i][0].last;
      end else begin
        req_valid[i]     <= 1'b0;
        req_data[8*i +: 8] <= 8'h00;
        req_last[i]      <= 1'b0;
      end
    end
  end

  // Transmitter model: drops ready after seeing tx_start, busy TX_BUSY cycles.
  always @(posedge clk) begin
    if (rst) begin
      tx_ready <= 1'b1;
      tcnt     <= 0;
    end else if (tx_start && tx_ready) begin
      tx_ready <= 1'b0;
      tcnt     <= TX_BUSY;
    end else if (!tx_ready) begin
      if (tcnt <= 1) tx_ready <= 1'b1;
      tcnt <= tcnt - 1;
    end
  end

  // Monitor: score every tx_start, measure last-byte-done to next-start delay.
  always @(negedge clk) begin
    if (rst) begin
      armed        <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (!ready_prev && tx_ready && pending_last) begin
        armed        <= 1'b1;
        rise_cyc     <= cyc;
        pending_last <= 1'b0;
      end
      if (tx_start) begin
        starts_seen <= starts_seen + 1;
        chk("start_with_tx_ready", tx_ready, 1);
        chk("start_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          automatic exp_t e = sb.pop_front();
          $display("[TB] tx_start word=0x%02h grant=%b req_ready=%b (exp req%0d 0x%02h)",
                   tx_word, grant, req_ready, e.req, e.data);
          chk("tx_word", tx_word, e.data);
          chk("req_ready_at_start", req_ready, 32'(1) << e.req);
          chk("grant_at_start", grant, 32'(1) << e.req);
          if (e.last) pending_last <= 1'b1;
          if (armed) begin
            deltas.push_back(cyc - rise_cyc);
            armed <= 1'b0;
          end
        end
      end else begin
        chk("req_ready_without_start", req_ready, 0);
      end
    end
    ready_prev <= tx_ready;
  end

  task automatic push_msg(input int r, input int len, input logic [23:0] bytes,
                          input int stall_idx, input int stall_len);
    for (int k = 0; k < len; k++) begin
      automatic item_t it;
      it.data  = bytes[8*k +: 8];
      it.last  = (k == len - 1);
      it.delay = (k == stall_idx) ? stall_len : 0;
      rq[r].push_back(it);
    end
  endtask

  task automatic expect_msg(input int r, input int len, input logic [23:0] bytes);
    for (int k = 0; k < len; k++) begin
      automatic exp_t e;
      e.req  = r;
      e.data = bytes[8*k +: 8];
      e.last = (k == len - 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk("drain_remaining", sb.size(), 0);
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input int budget);
    int n;
    n = 0;
    while (grant !== g && n < budget) begin @(negedge clk); n++; end
    chk("grant_wait", grant, g);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n;
    n = 0;
    while (starts_seen < target && n < budget) begin @(negedge clk); n++; end
    chk("start_wait", starts_seen >= target, 1);
  endtask

  // After the last byte: cycles busy stays high once tx_ready has returned.
  task automatic check_gap_len(input int expv);
    int n, cnt;
    n = 0;
    cnt = 0;
    while (tx_ready !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    while (tx_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    while (busy === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    chk("gap_len", cnt, expv);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   s0;
    vecs[0] = '{1, 1, 24'h0000A5};
    vecs[1] = '{0, 3, 24'h216968};   // "hi!"
    vecs[2] = '{0, 2, 24'h00FF00};
    vecs[3] = '{1, 3, 24'h030201};

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_word", tx_word, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single-requester messages, each followed by the full gap
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      push_msg(vecs[v].req, vecs[v].len, vecs[v].bytes, -1, 0);
      expect_msg(vecs[v].req, vecs[v].len, vecs[v].bytes);
      wait_drain(400);
      check_gap_len(G_A);
    end

    // Both requesters valid from reset
    rst = 1'b1;
    @(negedge clk);
`ifdef UART_ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < 4; k++) push_msg(0, 1, 24'(8'h71 + k), -1, 0);
    push_msg(1, 1, 24'h000081, -1, 0);
    for (int k = 0; k < 4; k++) expect_msg(0, 1, 24'(8'h71 + k));
    expect_msg(1, 1, 24'h000081);
`else
    push_msg(0, 2, 24'h001211, -1, 0);
    push_msg(0, 1, 24'h000013, -1, 0);
    push_msg(1, 2, 24'h002221, -1, 0);
    expect_msg(0, 2, 24'h001211);
    expect_msg(1, 2, 24'h002221);
    expect_msg(0, 1, 24'h000013);
`endif
    repeat (3) @(negedge clk);
    deltas.delete();
    rst = 1'b0;
    wait_drain(1500);
`ifdef UART_ARB_FIXED_PRIORITY_EN
    chk("multi_gap_count", deltas.size(), 4);
`else
    chk("multi_gap_count", deltas.size(), 2);
`endif
    foreach (deltas[k]) chk("multi_gap_delay", deltas[k], G_A + 3);

    // Stall inside a message: req1 must wait for req0's last byte plus gap
    check_gap_len(G_A);
    s0 = starts_seen;
    push_msg(0, 3, 24'h333231, 1, 50);
    expect_msg(0, 3, 24'h333231);
    expect_msg(1, 1, 24'h000041);
    wait_grant(2'b01, 50);
    push_msg(1, 1, 24'h000041, -1, 0);
    wait_starts(s0 + 1, 50);
    deltas.delete();
    repeat (25) @(negedge clk);
    chk("stall_grant_held", grant, 2'b01);
    chk("stall_no_start", starts_seen, s0 + 1);
    chk("stall_busy", busy, 1);
    wait_drain(600);
    chk("stall_gap_count", deltas.size(), 1);
    foreach (deltas[k]) chk("stall_gap_delay", deltas[k], G_A + 3);

    // Reset in the middle of a message
    check_gap_len(G_A);
    s0 = starts_seen;
    push_msg(0, 3, 24'h636261, -1, 0);
    expect_msg(0, 1, 24'h000061);
    wait_starts(s0 + 1, 100);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx_start", tx_start, 0);
    chk("midrst_tx_word", tx_word, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    rq[0].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_more_start", starts_seen, s0 + 1);
    chk("midrst_idle", busy, 0);
    chk("midrst_sb_empty", sb.size(), 0);

    // Zero gap: req1 then req0, second start 3 cycles after tx_ready rises
    rst = 1'b1;
    sel = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    deltas.delete();
    push_msg(1, 1, 24'h000051, -1, 0);
    expect_msg(1, 1, 24'h000051);
    expect_msg(0, 1, 24'h000052);
    wait_grant(2'b10, 20);
    push_msg(0, 1, 24'h000052, -1, 0);
    wait_drain(200);
    chk("nogap_count", deltas.size(), 1);
    foreach (deltas[k]) chk("nogap_delay", deltas[k], 3);
    check_gap_len(0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
